// File: rtl/map_bram_arbiter_pkg.sv
// Shared game parameters for the map BRAM arbiter: bus widths, FSM state
// encodings and port identifiers.
package map_bram_arbiter_pkg;

  localparam int MAP_ADDR_W = 19;
  localparam int MAP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RETURN = 2'd2
  } map_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } map_port_t;

  function automatic map_port_t other_port(input map_port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/map_bram_arbiter_pick.sv
// Winner selection between the interaction port (A) and the renderer port (B).
// With MAP_ARB_RR_EN defined a tie goes to the port not granted last; otherwise A wins.
module map_arb_pick
  import map_bram_arbiter_pkg::*;
(
  input  logic      a_req,
  input  logic      b_req,
`ifdef MAP_ARB_RR_EN
  input  map_port_t last,
`endif
  output logic      grant,
  output map_port_t winner
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant  = a_req | b_req;
    winner = a_req ? PORT_A : PORT_B;
`ifdef MAP_ARB_RR_EN
    if (a_req && b_req) begin
      winner = other_port(last);
    end
`endif
  end

endmodule

// File: rtl/map_bram_arbiter.sv
// Two-port arbiter in front of the single-port map BRAM (IDLE/ACCESS/RETURN FSM).
// Define MAP_ARB_RR_EN for round-robin arbitration; default is fixed priority A over B.
module map_bram_arbiter
  import map_bram_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  a_req,
  input  logic [MAP_ADDR_W-1:0] a_addr,
  input  logic                  a_wr,
  input  logic [MAP_DATA_W-1:0] a_dwrite,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [MAP_DATA_W-1:0] a_rdata,
  input  logic                  b_req,
  input  logic [MAP_ADDR_W-1:0] b_addr,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [MAP_DATA_W-1:0] b_rdata,
  output logic [MAP_ADDR_W-1:0] bram_addr,
  output logic                  bram_wr,
  output logic [MAP_DATA_W-1:0] bram_dwrite,
  input  logic [MAP_DATA_W-1:0] bram_data
);

  map_state_t state;
  map_port_t  owner;
  logic       op_wr;
  logic       pick_grant;
  map_port_t  pick_winner;
`ifdef MAP_ARB_RR_EN
  map_port_t  last_grant;
`endif

  map_arb_pick u_pick (
    .a_req  (a_req),
    .b_req  (b_req),
`ifdef MAP_ARB_RR_EN
    .last   (last_grant),
`endif
    .grant  (pick_grant),
    .winner (pick_winner)
  );

  // NOTE: all state is updated with <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      owner       <= PORT_B;
      op_wr       <= 1'b0;
      bram_addr   <= '0;
      bram_wr     <= 1'b0;
      bram_dwrite <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
`ifdef MAP_ARB_RR_EN
      last_grant  <= PORT_B;
`endif
    end else begin
      // Acks, rvalids and the write strobe are single-cycle pulses.
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      bram_wr  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (pick_grant) begin
            state <= ACCESS;
            owner <= pick_winner;
            if (pick_winner == PORT_A) begin
              a_ack     <= 1'b1;
              bram_addr <= a_addr;
              op_wr     <= a_wr;
              bram_wr   <= a_wr;
              if (a_wr) begin
                bram_dwrite <= a_dwrite;
              end
            end else begin
              b_ack     <= 1'b1;
              bram_addr <= b_addr;
              op_wr     <= 1'b0;
            end
`ifdef MAP_ARB_RR_EN
            last_grant <= pick_winner;
`endif
          end
        end

        ACCESS: state <= RETURN;

        RETURN: begin
          state <= IDLE;
          // BRAM read data for the ACCESS-cycle address is valid in this cycle.
          if (!op_wr) begin
            if (owner == PORT_A) begin
              a_rdata  <= bram_data;
              a_rvalid <= 1'b1;
            end else begin
              b_rdata  <= bram_data;
              b_rvalid <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_bram_arbiter.sv
// Self-checking bench for map_bram_arbiter: directed table, multi-cycle corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_map_bram_arbiter;

  logic        clk;
  logic        rstn;
  logic        a_req;
  logic [18:0] a_addr;
  logic        a_wr;
  logic [15:0] a_dwrite;
  logic        a_ack;
  logic        a_rvalid;
  logic [15:0] a_rdata;
  logic        b_req;
  logic [18:0] b_addr;
  logic        b_ack;
  logic        b_rvalid;
  logic [15:0] b_rdata;
  logic [18:0] bram_addr;
  logic        bram_wr;
  logic [15:0] bram_dwrite;
  logic [15:0] bram_data;

  map_bram_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .a_req       (a_req),
    .a_addr      (a_addr),
    .a_wr        (a_wr),
    .a_dwrite    (a_dwrite),
    .a_ack       (a_ack),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_addr      (b_addr),
    .b_ack       (b_ack),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .bram_addr   (bram_addr),
    .bram_wr     (bram_wr),
    .bram_dwrite (bram_dwrite),
    .bram_data   (bram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment BRAM (synchronous read, 1-cycle latency) and the model's view of memory.
  logic [15:0] bram_mem [logic [18:0]];
  logic [15:0] ref_mem  [logic [18:0]];

  function automatic logic [15:0] mem_default(input logic [18:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] bram_rd(input logic [18:0] a);
    return bram_mem.exists(a) ? bram_mem[a] : mem_default(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  always @(posedge clk) begin
    bram_data <= bram_rd(bram_addr);
    if (bram_wr) bram_mem[bram_addr] = bram_dwrite;
  end

  // Reference model state (winner codes: 0 none, 1 A, 2 B).
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_a_rdata;
  logic [15:0] exp_b_rdata;
  logic [18:0] exp_bram_addr;
  logic [15:0] exp_bram_dwrite;
`ifdef MAP_ARB_RR_EN
  int          ref_last;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input bit ar, input bit br);
    if (ar && br) begin
`ifdef MAP_ARB_RR_EN
      return (ref_last == 2) ? 1 : 2;
`else
      return 1;
`endif
    end
    return ar ? 1 : (br ? 2 : 0);
  endfunction

  task automatic note_grant(input int w);
`ifdef MAP_ARB_RR_EN
    if (w != 0) ref_last = w;
`endif
  endtask

  task automatic model_reset();
    exp_a_rdata     = '0;
    exp_b_rdata     = '0;
    exp_bram_addr   = '0;
    exp_bram_dwrite = '0;
`ifdef MAP_ARB_RR_EN
    ref_last = 2;
`endif
  endtask

  task automatic check_quiet(input string name);
    check({name, ".pulses"}, 32'({a_ack, b_ack, a_rvalid, b_rvalid, bram_wr}), 32'd0);
  endtask

  // One isolated transaction from IDLE: request presented for one sampling edge,
  // then ack / write strobe / read return checked cycle by cycle.
  task automatic do_txn(input string name, input bit ar, input bit aw, input logic [18:0] aa,
                        input logic [15:0] ad, input bit br, input logic [18:0] ba, input int w);
    bit          exp_wr;
    logic [15:0] exp_data;
    @(posedge clk); #1;
    a_req = ar; a_wr = aw; a_addr = aa; a_dwrite = ad; b_req = br; b_addr = ba;
    exp_wr = (w == 1) && aw;
    if (w == 1) exp_bram_addr = aa;
    else if (w == 2) exp_bram_addr = ba;
    exp_data = ref_rd(exp_bram_addr);
    if (exp_wr) begin
      ref_mem[aa]     = ad;
      exp_bram_dwrite = ad;
    end
    note_grant(w);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check({name, ".a_ack"},     32'(a_ack),       32'(w == 1));
    check({name, ".b_ack"},     32'(b_ack),       32'(w == 2));
    check({name, ".bram_addr"}, 32'(bram_addr),   32'(exp_bram_addr));
    check({name, ".bram_wr"},   32'(bram_wr),     32'(exp_wr));
    check({name, ".dwrite"},    32'(bram_dwrite), 32'(exp_bram_dwrite));
    @(negedge clk);
    check_quiet({name, ".return"});
    @(negedge clk);
    if (!exp_wr && w == 1) exp_a_rdata = exp_data;
    if (!exp_wr && w == 2) exp_b_rdata = exp_data;
    check({name, ".a_rvalid"}, 32'(a_rvalid), 32'(!exp_wr && w == 1));
    check({name, ".b_rvalid"}, 32'(b_rvalid), 32'(!exp_wr && w == 2));
    check({name, ".a_rdata"},  32'(a_rdata),  32'(exp_a_rdata));
    check({name, ".b_rdata"},  32'(b_rdata),  32'(exp_b_rdata));
    check({name, ".bram_wr_idle"}, 32'(bram_wr), 32'd0);
  endtask

  typedef struct {
    bit          a_req;
    bit          a_wr;
    logic [18:0] a_addr;
    logic [15:0] a_dwrite;
    bit          b_req;
    logic [18:0] b_addr;
    int          exp_rr;
    int          exp_fp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d_a;
    logic [15:0] d_b;
    int          w;

    rstn = 1'b0; a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_dwrite = '0;
    b_req = 1'b0; b_addr = '0;
    model_reset();
    bram_mem[19'h00105] = 16'h0042;
    ref_mem[19'h00105]  = 16'h0042;

    // Inputs, then expected winner under round-robin and under fixed priority.
    vecs[0] = '{1'b1, 1'b0, 19'h00105, 16'h0000, 1'b0, 19'h00000, 1, 1};
    vecs[1] = '{1'b1, 1'b1, 19'h00200, 16'h0007, 1'b0, 19'h00000, 1, 1};
    vecs[2] = '{1'b1, 1'b0, 19'h00200, 16'h0000, 1'b0, 19'h00000, 1, 1};
    vecs[3] = '{1'b0, 1'b0, 19'h00000, 16'h0000, 1'b1, 19'h00105, 2, 2};
    vecs[4] = '{1'b1, 1'b0, 19'h7FFFF, 16'h0000, 1'b1, 19'h00000, 1, 1};
    vecs[5] = '{1'b1, 1'b1, 19'h00010, 16'hFFFF, 1'b1, 19'h7FFFF, 2, 1};
    vecs[6] = '{1'b1, 1'b0, 19'h00010, 16'h0000, 1'b1, 19'h00001, 1, 1};
    vecs[7] = '{1'b1, 1'b0, 19'h00200, 16'h0000, 1'b1, 19'h00010, 2, 1};
    vecs[8] = '{1'b0, 1'b1, 19'h00333, 16'h1111, 1'b0, 19'h00444, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset.bram_addr", 32'(bram_addr),   32'd0);
    check("reset.dwrite",    32'(bram_dwrite), 32'd0);
    check("reset.a_rdata",   32'(a_rdata),     32'd0);
    check("reset.b_rdata",   32'(b_rdata),     32'd0);
    #2 rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
`ifdef MAP_ARB_RR_EN
      w = vecs[i].exp_rr;
`else
      w = vecs[i].exp_fp;
`endif
      do_txn($sformatf("vec%0d", i), vecs[i].a_req, vecs[i].a_wr, vecs[i].a_addr,
             vecs[i].a_dwrite, vecs[i].b_req, vecs[i].b_addr, w);
    end

    // Both ports hold req across four back-to-back grants.
    @(posedge clk); #1;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 19'h00105; b_req = 1'b1; b_addr = 19'h00010;
    for (int g = 0; g < 4; g++) begin
      w = model_pick(1'b1, 1'b1);
      note_grant(w);
      exp_bram_addr = (w == 1) ? a_addr : b_addr;
      @(posedge clk); #1;
      if (g == 3) begin a_req = 1'b0; b_req = 1'b0; end
      @(negedge clk);
      check($sformatf("held%0d.a_ack", g), 32'(a_ack), 32'(w == 1));
      check($sformatf("held%0d.b_ack", g), 32'(b_ack), 32'(w == 2));
      check($sformatf("held%0d.bram_addr", g), 32'(bram_addr), 32'(exp_bram_addr));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      if (w == 1) exp_a_rdata = ref_rd(19'h00105);
      else        exp_b_rdata = ref_rd(19'h00010);
      check($sformatf("held%0d.a_rvalid", g), 32'(a_rvalid), 32'(w == 1));
      check($sformatf("held%0d.b_rvalid", g), 32'(b_rvalid), 32'(w == 2));
      check($sformatf("held%0d.a_rdata", g),  32'(a_rdata),  32'(exp_a_rdata));
      check($sformatf("held%0d.b_rdata", g),  32'(b_rdata),  32'(exp_b_rdata));
    end

    // B requests while A is in ACCESS: served in the IDLE after A's RETURN.
    @(posedge clk); #1;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 19'h00200; b_addr = 19'h00105;
    d_a = ref_rd(19'h00200);
    d_b = ref_rd(19'h00105);
    note_grant(1);
    note_grant(2);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin a_req = 1'b0; b_req = 1'b1; end
      if (c == 4) b_req = 1'b0;
      @(negedge clk);
      check($sformatf("late_b.c%0d.a_ack", c),    32'(a_ack),    32'(c == 1));
      check($sformatf("late_b.c%0d.b_ack", c),    32'(b_ack),    32'(c == 4));
      check($sformatf("late_b.c%0d.a_rvalid", c), 32'(a_rvalid), 32'(c == 3));
      check($sformatf("late_b.c%0d.b_rvalid", c), 32'(b_rvalid), 32'(c == 6));
      if (c == 3) check("late_b.a_rdata", 32'(a_rdata), 32'(d_a));
      if (c == 6) check("late_b.b_rdata", 32'(b_rdata), 32'(d_b));
    end
    exp_a_rdata   = d_a;
    exp_b_rdata   = d_b;
    exp_bram_addr = 19'h00105;

    // Randomized traffic against the model.
    for (int r = 0; r < 40; r++) begin
      bit          ar, aw, br;
      logic [18:0] aa, ba;
      logic [15:0] ad;
      ar = 1'($urandom_range(0, 1));
      aw = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      aa = 19'($urandom_range(0, 15));
      ba = 19'($urandom_range(0, 15));
      ad = 16'($urandom);
      w  = model_pick(ar, br);
      do_txn($sformatf("rnd%0d", r), ar, aw, aa, ad, br, ba, w);
    end

    // Reset pulsed in the middle of a write ACCESS cycle.
    @(posedge clk); #1;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 19'h00300; a_dwrite = 16'h1234;
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check("midrst.bram_wr_before", 32'(bram_wr), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_quiet("midrst.async");
    check("midrst.bram_addr", 32'(bram_addr),   32'd0);
    check("midrst.dwrite",    32'(bram_dwrite), 32'd0);
    check("midrst.a_rdata",   32'(a_rdata),     32'd0);
    check("midrst.b_rdata",   32'(b_rdata),     32'd0);
    @(posedge clk); #2 rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_quiet($sformatf("midrst.after%0d", c));
    end

    // Last-grant is back to B after reset, and the aborted write left memory alone.
    do_txn("post_rst.tie", 1'b1, 1'b0, 19'h00300, 16'h0000, 1'b1, 19'h00105,
           model_pick(1'b1, 1'b1));
    do_txn("post_rst.b", 1'b0, 1'b0, 19'h00000, 16'h0000, 1'b1, 19'h00300, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/map_bram_arbiter.md
MAP_BRAM_ARBITER -- requirements
Module: map_bram_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic is rising-edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have ports a_req (in, 1), a_addr (in, 19), a_wr (in, 1) and a_dwrite (in, 16): port A request, the interaction requester, read or write.
REQ-004 SHALL have ports a_ack (out, 1), a_rvalid (out, 1) and a_rdata (out, 16): port A grant pulse and read return.
REQ-005 SHALL have ports b_req (in, 1) and b_addr (in, 19): port B request, the renderer, read-only.
REQ-006 SHALL have ports b_ack (out, 1), b_rvalid (out, 1) and b_rdata (out, 16): port B grant pulse and read return.
REQ-007 SHALL have ports bram_addr (out, 19), bram_wr (out, 1), bram_dwrite (out, 16) and bram_data (in, 16): the single map BRAM port, synchronous read, 1-cycle latency.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS and RETURN; transitions IDLE->ACCESS on any sampled request, ACCESS->RETURN unconditionally, RETURN->IDLE unconditionally.
REQ-009 SHALL sample requests only in IDLE; requests arriving in ACCESS or RETURN are held by the requester and serviced in the next IDLE.
REQ-010 On the IDLE->ACCESS edge, SHALL register the winner's address into bram_addr, pulse the winner's ack for exactly one cycle, and record the winner and the op.
REQ-011 For a port A write, SHALL assert bram_wr with bram_dwrite=a_dwrite for exactly the ACCESS cycle; neither rvalid SHALL pulse.
REQ-012 For a read, SHALL hold bram_wr=0, capture bram_data into the winner's rdata on the RETURN->IDLE edge, and pulse that winner's rvalid for one cycle.
REQ-013 Read latency: rvalid SHALL rise exactly 3 cycles after the edge at which req was sampled; peak throughput is one access per 3 cycles.
REQ-014 The non-winning port's rdata SHALL remain unchanged and its rvalid SHALL stay 0.
REQ-015 bram_addr SHALL hold its last value outside grants; bram_wr SHALL be 0 in every state except a write ACCESS cycle.
REQ-016 A requester SHALL drop req the cycle after ack; req still high in the following IDLE counts as a new request.
REQ-017 When a_req and b_req are simultaneous, the winner SHALL be decided per REQ-020/REQ-021.

Reset
REQ-018 While rstn=0, SHALL set state=IDLE, bram_addr=0, bram_wr=0, bram_dwrite=0, both acks=0, both rvalids=0, both rdatas=0, and last-grant=B.
REQ-019 Reset asserted mid-access SHALL abort the access immediately: bram_wr drops asynchronously and no rvalid follows after release.

Configuration
REQ-020 With MAP_ARB_RR_EN defined, SHALL arbitrate round-robin: on a simultaneous request, the port not granted last wins, and last-grant updates on every grant.
REQ-021 Without MAP_ARB_RR_EN, SHALL use fixed priority with A over B, and last-grant logic SHALL be omitted.

Structure
REQ-022 SHALL take MAP_ADDR_W=19, MAP_DATA_W=16 and the FSM state encodings from the shared game parameters package.
REQ-023 SHALL place winner selection in one sub-module, map_arb_pick, which is combinational given last-grant; the FSM and datapath stay in the top.

Verification
REQ-024 Scenario: A read addr 0x00105 with bram returning 0x0042 -> a_ack 1 cycle after the sampling edge; a_rvalid high 3 cycles after it with a_rdata=0x0042; b_rvalid=0.
REQ-025 Scenario: A write addr 0x00200 data 0x0007 -> bram_wr=1 for exactly 1 cycle with bram_addr=0x00200 and bram_dwrite=0x0007; no rvalid on either port.
REQ-026 Scenario: a_req and b_req simultaneous and held across 4 grants -> with RR the order is A,B,A,B (last-grant=B after reset); without RR the order is A,A,A,A.
REQ-027 Scenario: b_req asserted during A's ACCESS -> b_ack occurs in the IDLE after A's RETURN; b_rvalid arrives 6 cycles after A's sampling edge.
REQ-028 Scenario: rstn pulsed low during a write ACCESS -> bram_wr=0 immediately and all outputs read 0; after release, no stray ack or rvalid appears.
